// File: rtl/equiv_mismatch_monitor.sv
// equiv_mismatch_monitor: compares two candidate outputs after a warmup window, counts mismatches and captures the first failure
module equiv_mismatch_monitor #(
   parameter int WIDTH        = 91,
   parameter int WARMUP_CYC   = 4,
   parameter int NUM_CHECKS   = 1024,
   parameter int CNT_W        = 16,
   parameter int HALT_ON_FAIL = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             valid_in,
   input  logic [WIDTH-1:0] y_1,
   input  logic [WIDTH-1:0] y_2,
   output logic             busy,
   output logic             done,
   output logic             fail,
   output logic [CNT_W-1:0] mismatch_cnt,
   output logic [CNT_W-1:0] check_cnt,
   output logic [CNT_W-1:0] first_fail_idx,
   output logic [WIDTH-1:0] first_diff
);
   typedef enum logic [1:0] {IDLE, WARMUP, CHECK, DONE} state_t;
   localparam logic [CNT_W-1:0] MAX = '1;
   state_t state, state_d;
   logic en_q, s_v, start, mis, halt, step_warm, step_chk;
   logic [WIDTH-1:0] s_diff;
   logic [CNT_W-1:0] warm_cnt, warm_inc, chk_inc, mm_inc;
   assign busy      = (state == WARMUP) || (state == CHECK);
   assign done      = (state == DONE);
   assign start     = en & ~en_q;
   assign mis       = (s_diff !== '0);
   assign halt      = (HALT_ON_FAIL != 0);
   assign warm_inc  = (warm_cnt == MAX) ? warm_cnt : warm_cnt + 1'b1;
   assign chk_inc   = (check_cnt == MAX) ? check_cnt : check_cnt + 1'b1;
   assign mm_inc    = (mismatch_cnt == MAX) ? mismatch_cnt : mismatch_cnt + 1'b1;
   // dropping en discards the sample in flight, so stage 2 only acts while en is still high
   assign step_warm = en && s_v && (state == WARMUP);
   assign step_chk  = en && s_v && (state == CHECK);
   // stage 1: register the sample and its diff; anything outside WARMUP/CHECK is dropped here
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_v    <= 1'b0;
         s_diff <= '0;
         en_q   <= 1'b0;
      end else begin
         s_v    <= valid_in & busy;
         s_diff <= y_1 ^ y_2;
         en_q   <= en;
      end
   end
   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_d;
   end
   // next-state logic
   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (start) state_d = (WARMUP_CYC == 0) ? CHECK : WARMUP;
         WARMUP:  if (!en) state_d = IDLE;
                  else if (s_v && warm_cnt == CNT_W'(WARMUP_CYC - 1)) state_d = CHECK;
         CHECK:   if (!en) state_d = IDLE;
                  else if (s_v && (chk_inc == CNT_W'(NUM_CHECKS) || (mis && halt))) state_d = DONE;
         DONE:    if (!en) state_d = IDLE;
      endcase
   end
   // stage 2: warmup/check counters and sticky first-failure capture, cleared at each run start
   always_ff @(posedge clk or posedge rst) begin
      if (rst || (state == IDLE && start)) begin
         fail           <= 1'b0;
         mismatch_cnt   <= '0;
         check_cnt      <= '0;
         first_fail_idx <= '0;
         first_diff     <= '0;
         warm_cnt       <= '0;
      end else if (step_warm) begin
         warm_cnt <= warm_inc;
      end else if (step_chk) begin
         check_cnt <= chk_inc;
         if (mis) begin
            mismatch_cnt <= mm_inc;
            if (!fail) begin
               fail           <= 1'b1;
               first_fail_idx <= check_cnt;
               first_diff     <= s_diff;
            end
         end
      end
   end
endmodule
